stack_call_ctrl: RTL and testbench
==================================

// Module: stack_call_ctrl
// PURPOSE
//  Initiator side of the stack-memory interface. Turns CALL/RET requests from the control unit into
//  single-word MemWR/MemRD transactions with StackOP=1, which the stack pointer tracks.
//  Reads sp from the stack pointer and drives the data-memory address, write data and strobes.
//  Returns the popped return address to the PC logic. Sits between control unit, data memory and SP.
// PARAMETERS
//  MEM_DEPTH    16              data memory depth in 32-bit words
//  STACK_BASE   MEM_DEPTH/2     lowest stack word address; sp==STACK_BASE means empty
//  STACK_LIMIT  MEM_DEPTH       one past the top stack word; sp==STACK_LIMIT means full
//  ADDR_W       $clog2(MEM_DEPTH)  mem_addr width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  call_req     in   1       push pc_next; sampled only in IDLE
//  ret_req      in   1       pop return address; sampled only in IDLE
//  pc_next      in   32      return address to push
//  sp           in   32      current stack pointer = next free slot
//  mem_rdata    in   32      data memory read data; valid 1 cycle after MemRD
//  mem_addr     out  ADDR_W  stack word address
//  mem_wdata    out  32      push data
//  MemWR        out  1       memory write strobe
//  MemRD        out  1       memory read strobe
//  StackOP      out  1       high with every stack strobe
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle completion pulse
//  pc_ret       out  32      last popped return address; valid while done=1 after a RET
// BEHAVIOUR
//  Reset: state=IDLE; MemWR=MemRD=StackOP=busy=done=0; mem_addr=0; mem_wdata=0; pc_ret=0.
//  States: IDLE, PUSH, POP, POP_WAIT, DONE. Outputs decode from state; pc_ret and mem_wdata are registers.
//  IDLE: call_req=1 -> PUSH and latch pc_next into mem_wdata. Otherwise ret_req=1 -> POP.
//    If both are high, CALL wins; RET is taken only if ret_req is still high on return to IDLE.
//  PUSH (1 cycle): MemWR=StackOP=1, mem_addr=sp[ADDR_W-1:0]. The SP increments on this edge. -> DONE.
//  POP (1 cycle): MemRD=StackOP=1, mem_addr=sp-1. The SP decrements on this edge. -> POP_WAIT.
//  POP_WAIT: pc_ret <= mem_rdata -> DONE.
//  DONE: done=1 -> IDLE. The requester deasserts its request while done=1. A request still high
//    in IDLE is treated as a new request.
//  Latency from accept edge to done: CALL=2 cycles, RET=3 cycles. Requests are ignored while busy=1.
//  Full: call when sp>=STACK_LIMIT -> PUSH without strobes -> DONE. No write; sp is unchanged.
//  Empty: ret when sp<=STACK_BASE -> POP and POP_WAIT without strobes. pc_ret holds its value -> DONE.
//  Strobes never assert outside PUSH/POP. MemWR and MemRD are never high together.
//  Reset mid-operation: return to IDLE next edge; no further strobe is issued.
//  A pop already in flight does not update pc_ret.
// CONFIGURATION
//  STACK_FAULT_EN defined: adds output fault[1:0] = {overflow, underflow}.
//    fault bits are sticky and set on the full/empty cases. Only rst clears them.
//  STACK_FAULT_EN undefined: no fault port. Full/empty operations are silently dropped;
//    done still pulses.
// STRUCTURE
//  stack_pkg: state enum typedef, default STACK_BASE/STACK_LIMIT constants, fault bit indices.
//  Sub-module stack_bounds: combinational sp compare giving is_full/is_empty.
//  The FSM, datapath registers and strobe decode stay in stack_call_ctrl.
// TESTING
//  rst, sp=8, call_req with pc_next=0x24 -> one cycle with MemWR=StackOP=1, addr=8, wdata=0x24;
//    done 2 cycles after accept.
//  sp=9, mem[8]=0x24, ret_req -> MemRD=1 with addr=8; done 3 cycles after accept with pc_ret=0x24.
//  call_req and ret_req together in IDLE -> push occurs first; pop follows only if ret_req is held.
//  sp=16, call_req -> no MemWR; done pulses; fault[1]=1 with STACK_FAULT_EN.
//  sp=8, ret_req -> no MemRD; pc_ret unchanged; fault[0]=1 with STACK_FAULT_EN.
//  rst asserted in POP_WAIT -> IDLE next cycle; all outputs 0; pc_ret=0; no strobe afterwards.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the stack call/return controller: FSM encodings, default
// stack bounds and fault bit positions.
package stack_pkg;

  localparam int unsigned DefMemDepth   = 16;
  localparam int unsigned DefStackBase  = DefMemDepth / 2;
  localparam int unsigned DefStackLimit = DefMemDepth;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StPush    = 3'd1;
  localparam state_t StPop     = 3'd2;
  localparam state_t StPopWait = 3'd3;
  localparam state_t StDone    = 3'd4;

  localparam int unsigned FaultOvfIdx = 1;
  localparam int unsigned FaultUdfIdx = 0;

endpackage

// File: rtl/stack_call_ctrl_if.sv
// Bus between the stack call controller and its neighbours (control unit, data memory, SP).
// master = controller side, slave = environment side.
interface stack_call_ctrl_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic              call_req;
  logic              ret_req;
  logic [31:0]       pc_next;
  logic [31:0]       sp;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              MemWR;
  logic              MemRD;
  logic              StackOP;
  logic              busy;
  logic              done;
  logic [31:0]       pc_ret;

  modport master (
    input  call_req, ret_req, pc_next, sp, mem_rdata,
    output mem_addr, mem_wdata, MemWR, MemRD, StackOP, busy, done, pc_ret
  );

  modport slave (
    output call_req, ret_req, pc_next, sp, mem_rdata,
    input  mem_addr, mem_wdata, MemWR, MemRD, StackOP, busy, done, pc_ret
  );

endinterface

// File: rtl/stack_bounds.sv
// Combinational stack pointer range check: full at/above the limit, empty at/below the base.
module stack_bounds
  import stack_pkg::*;
#(
  parameter int unsigned STACK_BASE  = DefStackBase,
  parameter int unsigned STACK_LIMIT = DefStackLimit
) (
  input  logic [31:0] sp_i,
  output logic        is_full_o,
  output logic        is_empty_o
);

  assign is_full_o  = (sp_i >= 32'(STACK_LIMIT));
  assign is_empty_o = (sp_i <= 32'(STACK_BASE));

endmodule

// File: rtl/stack_call_ctrl.sv
// CALL/RET stack-memory initiator: single-word push/pop transactions with StackOP strobes.
// Define STACK_FAULT_EN to add the sticky fault[1:0] = {overflow, underflow} output.
module stack_call_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = DefMemDepth,
  parameter int unsigned STACK_BASE  = MEM_DEPTH / 2,
  parameter int unsigned STACK_LIMIT = MEM_DEPTH,
  parameter int unsigned ADDR_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  stack_call_ctrl_if.master       bus
`ifdef STACK_FAULT_EN
  ,
  output logic [1:0]              fault
`endif
);

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_ret_q, pc_ret_d;
  logic        is_full, is_empty;
  logic        wr_en, rd_en;

  stack_bounds #(
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds (
    .sp_i       (bus.sp),
    .is_full_o  (is_full),
    .is_empty_o (is_empty)
  );

  // drop_q marks an accepted operation that hit a bound: the FSM still walks its states
  // so done pulses with the normal latency, but no strobe or pc_ret update happens.
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    wdata_d  = wdata_q;
    pc_ret_d = pc_ret_q;
    unique case (state_q)
      StIdle: begin
        if (bus.call_req) begin
          state_d = StPush;
          wdata_d = bus.pc_next;
          drop_d  = is_full;
        end else if (bus.ret_req) begin
          state_d = StPop;
          drop_d  = is_empty;
        end
      end
      StPush:    state_d = StDone;
      StPop:     state_d = StPopWait;
      StPopWait: begin
        if (!drop_q) pc_ret_d = bus.mem_rdata;
        state_d = StDone;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      drop_q   <= 1'b0;
      wdata_q  <= '0;
      pc_ret_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      wdata_q  <= wdata_d;
      pc_ret_q <= pc_ret_d;
    end
  end

`ifdef STACK_FAULT_EN
  logic [1:0] fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (state_q == StIdle) begin
      if (bus.call_req && is_full)                     fault_d[FaultOvfIdx] = 1'b1;
      if (!bus.call_req && bus.ret_req && is_empty)    fault_d[FaultUdfIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= '0;
    else     fault_q <= fault_d;
  end

  assign fault = fault_q;
`endif

  always_comb begin
    wr_en        = (state_q == StPush) && !drop_q;
    rd_en        = (state_q == StPop) && !drop_q;
    bus.MemWR    = wr_en;
    bus.MemRD    = rd_en;
    bus.StackOP  = wr_en | rd_en;
    bus.busy     = (state_q != StIdle);
    bus.done     = (state_q == StDone);
    bus.mem_wdata = wdata_q;
    bus.pc_ret    = pc_ret_q;
    bus.mem_addr  = '0;
    if (wr_en)      bus.mem_addr = bus.sp[ADDR_W-1:0];
    else if (rd_en) bus.mem_addr = bus.sp[ADDR_W-1:0] - ADDR_W'(1);
  end

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Directed bench for stack_call_ctrl with a memory/SP model and an event scoreboard.
module tb_stack_call_ctrl;

  localparam int unsigned AW = 4;

  typedef struct {
    logic [3:0]    vec;   // {MemWR, MemRD, done, StackOP}
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            chk_pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_call_ctrl_if #(.ADDR_W(AW)) bus ();

`ifdef STACK_FAULT_EN
  logic [1:0] fault;
`endif

  stack_call_ctrl #(
    .MEM_DEPTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STACK_FAULT_EN
    ,
    .fault (fault)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  logic [31:0] mem [16];
  logic        sp_set = 1'b0;
  logic [31:0] sp_val = 32'd0;

  // Memory and stack pointer model reacting to the DUT strobes.
  always @(posedge clk) begin
    if (sp_set)                           bus.sp <= sp_val;
    else if (bus.MemWR && bus.StackOP)    bus.sp <= bus.sp + 32'd1;
    else if (bus.MemRD && bus.StackOP)    bus.sp <= bus.sp - 32'd1;
    if (bus.MemWR) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.MemRD) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    q.push_back('{vec: 4'b1001, addr: a, data: d, chk_pc: 1'b0});
  endfunction

  function automatic void push_rd(input logic [AW-1:0] a);
    q.push_back('{vec: 4'b0101, addr: a, data: 32'd0, chk_pc: 1'b0});
  endfunction

  function automatic void push_done(input bit c, input logic [31:0] pc);
    q.push_back('{vec: 4'b0010, addr: '0, data: pc, chk_pc: c});
  endfunction

  exp_t       e;
  logic [3:0] obs;

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.MemWR === 1'b1 || bus.MemRD === 1'b1 || bus.done === 1'b1)) begin
      obs = {bus.MemWR, bus.MemRD, bus.done, bus.StackOP};
      if (q.size() == 0) begin
        chk("unexpected_event", 32'(obs), 32'd0);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(obs), 32'(e.vec));
        if (e.vec[3]) begin
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", bus.mem_wdata, e.data);
        end
        if (e.vec[2]) chk("rd_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.vec[1] && e.chk_pc) chk("pc_ret", bus.pc_ret, e.data);
      end
    end
  end

  task automatic set_sp(input logic [31:0] v);
    sp_set = 1'b1;
    sp_val = v;
    @(posedge clk); #1;
    sp_set = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) k = i;
    end
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit c, input bit r, input logic [31:0] pc, input bit hold_ret,
                        input int lat, input string tag);
    bus.pc_next  = pc;
    bus.call_req = c;
    bus.ret_req  = r;
    @(posedge clk); #1;
    bus.call_req = 1'b0;
    if (!hold_ret) bus.ret_req = 1'b0;
    wait_done(lat, tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_wr"},    32'(bus.MemWR), 32'd0);
    chk({tag, "_rd"},    32'(bus.MemRD), 32'd0);
    chk({tag, "_sop"},   32'(bus.StackOP), 32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_pcret"}, bus.pc_ret, 32'd0);
`ifdef STACK_FAULT_EN
    chk({tag, "_fault"}, 32'(fault), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.pc_next  = 32'd0;
    set_sp(32'd8);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Push 0x24 at sp=8.
    push_wr(4'd8, 32'h24);
    push_done(1'b0, 32'd0);
    run_op(1'b1, 1'b0, 32'h24, 1'b0, 2, "call");

    // sp=9 now: pop returns 0x24 from word 8.
    push_rd(4'd8);
    push_done(1'b1, 32'h24);
    run_op(1'b0, 1'b1, 32'h0, 1'b0, 3, "ret");

    // CALL and RET together, RET held: push first, then pop of the same word.
    push_wr(4'd8, 32'h40);
    push_done(1'b0, 32'd0);
    push_rd(4'd8);
    push_done(1'b1, 32'h40);
    run_op(1'b1, 1'b1, 32'h40, 1'b1, 2, "both_push");
    @(posedge clk); #1;
    bus.ret_req = 1'b0;
    wait_done(3, "both_pop");

    // CALL and RET together, RET dropped after accept: only the push happens.
    push_wr(4'd8, 32'h55);
    push_done(1'b0, 32'd0);
    run_op(1'b1, 1'b1, 32'h55, 1'b0, 2, "both_only_push");
    repeat (4) @(posedge clk);
    #1;
    chk("no_pop_busy", 32'(bus.busy), 32'd0);
    chk("no_pop_sp", bus.sp, 32'd9);

    // Full: no write, done still pulses, sp unchanged.
    set_sp(32'd16);
    push_done(1'b0, 32'd0);
    run_op(1'b1, 1'b0, 32'h99, 1'b0, 2, "full");
    chk("full_sp", bus.sp, 32'd16);
`ifdef STACK_FAULT_EN
    chk("fault_ovf", 32'(fault), 32'd2);
`endif

    // Empty: no read, pc_ret keeps the last popped value.
    set_sp(32'd8);
    push_done(1'b1, 32'h40);
    run_op(1'b0, 1'b1, 32'h0, 1'b0, 3, "empty");
    chk("empty_sp", bus.sp, 32'd8);
`ifdef STACK_FAULT_EN
    chk("fault_udf", 32'(fault), 32'd3);
`endif

    // Reset while in POP_WAIT.
    set_sp(32'd9);
    push_rd(4'd8);
    bus.ret_req = 1'b1;
    @(posedge clk); #1;
    bus.ret_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
